controller_poller_m: RTL
========================

// Module: controller_poller_m
// PURPOSE
//   Polls both NES-style serial game controllers and presents their button
//   states in parallel to the memory-mapped controller registers read by the CPU.
//   Runs in the GPU clock domain. A poll starts on a one-cycle `start` pulse,
//   which top_m ties to the vblank-start strobe.
//   Each poll generates latch/clock waveforms, shifts in 8 bits per port, and
//   commits both ports atomically. It also keeps a sticky "newly pressed" mask.
// PARAMETERS
//   HALF_PERIOD  6  GPU cycles per half controller-clock period (>=1); 6 -> ~1.05 MHz
// PORTS
//   clk_12_5875               in   1  GPU clock; sole clock of the block
//   rst                       in   1  synchronous, active-high reset
//   start                     in   1  1-cycle poll request; ignored while busy
//   clear_pressed             in   1  1-cycle clear of both pressed masks
//   controller_clk            out  1  serial clock to both controllers, idles high
//   controller_latch          out  1  parallel-load strobe to both controllers, active high
//   controller_1_data_in_B    in   1  serial data port 1, active low (0 = pressed)
//   controller_2_data_in_B    in   1  serial data port 2, active low
//   controller_1_buttons_out  out  8  committed buttons port 1, 1 = pressed
//   controller_2_buttons_out  out  8  committed buttons port 2
//   controller_1_pressed_out  out  8  sticky rising-edge mask port 1
//   controller_2_pressed_out  out  8  sticky rising-edge mask port 2
//   busy                      out  1  high from the cycle after accepted start until commit
//   valid                     out  1  1-cycle pulse in the commit cycle
// BEHAVIOUR
//   Reset values: all outputs 0, except controller_clk = 1. FSM -> IDLE, prescaler = 0.
//   All outputs are registered.
//   FSM: IDLE -> LATCH -> {SHIFT_LO -> SHIFT_HI} x8 -> COMMIT -> IDLE.
//   - IDLE: latch=0, clk=1, busy=0. If start=1, go to LATCH next cycle.
//   - LATCH: latch=1, clk=1 for 2*HALF_PERIOD cycles.
//   - SHIFT_LO bit k (k=0..7): clk=0 for HALF_PERIOD cycles.
//     data_in_B is sampled on the last cycle of this state.
//   - SHIFT_HI bit k: clk=1 for HALF_PERIOD cycles. Its rising edge makes the
//     controller present bit k+1. After k=7, go to COMMIT.
//   - COMMIT (1 cycle): buttons_out <= ~shift; valid=1;
//     pressed <= pressed | (~shift & ~buttons_out_old). Then IDLE.
//   Bit order: bit k of buttons = k-th bit received.
//     0=A 1=B 2=SELECT 3=START 4=UP 5=DOWN 6=LEFT 7=RIGHT.
//   Poll length: start seen at cycle 0 -> latch rises at cycle 1.
//     valid asserts at cycle 1 + 18*HALF_PERIOD (109 for the default).
//   buttons_out changes only in COMMIT. Partial shifts are never visible.
//   start while busy or in COMMIT: ignored, not queued.
//   clear_pressed: pressed <= 0 next cycle.
//     If it coincides with COMMIT, pressed <= new edges only (clear applies first).
//   rst mid-poll: abort immediately to reset values; the partial shift is discarded.
//   Prescaler: counter of width $clog2(2*HALF_PERIOD+1). Reloads on every state change.
// STRUCTURE
//   controller_pkg:
//     - poll_state_t enum {IDLE, LATCH, SHIFT_LO, SHIFT_HI, COMMIT}
//     - button index localparams BTN_A..BTN_RIGHT
//     - BUTTON_COUNT = 8
//   Sub-module controller_channel_m, instantiated twice. Per port it holds:
//     - the shift register, fed by `sample` and `commit` strobes from the parent FSM
//     - buttons_out, pressed, and clear handling
//   Parent holds the FSM, prescaler, bit counter, latch and clk generation.
// TESTING (bench: two controller_m models, HALF_PERIOD=6)
//   1 Reset.
//     Stimulus: rst for 2 cycles, then idle 200 cycles.
//     Required: clk=1, latch=0, buttons=0, busy=0, no valid pulse.
//   2 Basic poll.
//     Stimulus: ctrl1 = 8'h09 (A+START), ctrl2 = 8'h80 (RIGHT); start pulse.
//     Required: latch high for exactly 12 cycles; 8 clk low pulses of 6 cycles;
//       valid at cycle 109; buttons 8'h09 / 8'h80.
//   3 Edge mask.
//     Stimulus: poll with 8'h01, then poll with 8'h03.
//     Required: pressed1 = 8'h01 after the first poll, 8'h03 after the second.
//     Then clear_pressed -> pressed1 = 0 while buttons1 stays 8'h03.
//   4 Clear vs commit.
//     Stimulus: pressed1 = 8'h01; the next poll with 8'h05 has clear_pressed
//       in the COMMIT cycle.
//     Required: pressed1 = 8'h04.
//   5 Ignored start.
//     Stimulus: second start at cycle 50 of a poll.
//     Required: exactly one valid pulse; the next latch only after a new start.
//   6 Reset mid-poll.
//     Stimulus: rst at cycle 60, then a full poll with 8'hFF.
//     Required: outputs at reset values after the rst cycle; then buttons = 8'hFF,
//       with no residue from the aborted poll.

Source files
------------

// File: rtl/controller_poller_m_pkg.sv
// Shared types and constants for the NES controller poller.
package controller_poller_m_pkg;

    // Poll sequencer states. The encoding is visible on the debug port.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        COMMIT   = 3'd4
    } poll_state_t;

    // Bit positions in the button bytes, in the order the controller shifts them out.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int BUTTON_COUNT = 8;

endpackage

// File: rtl/controller_poller_m_if.sv
// Signal bundle between the controller poller, the two controller ports and the CPU side.
// Handshake: `start` is a one-cycle request, accepted only while busy=0 and valid=0;
// `busy` is high from the cycle after acceptance until the commit cycle; `valid` pulses
// for exactly that one commit cycle, and the button/pressed bytes hold the new values
// from the following cycle on. Requests arriving while busy or in the commit cycle are dropped.
interface controller_poller_m_if;
    import controller_poller_m_pkg::*;

    logic                    start;
    logic                    clear_pressed;
    logic                    controller_clk;
    logic                    controller_latch;
    logic                    controller_1_data_in_B;
    logic                    controller_2_data_in_B;
    logic [BUTTON_COUNT-1:0] controller_1_buttons_out;
    logic [BUTTON_COUNT-1:0] controller_2_buttons_out;
    logic [BUTTON_COUNT-1:0] controller_1_pressed_out;
    logic [BUTTON_COUNT-1:0] controller_2_pressed_out;
    logic                    busy;
    logic                    valid;

    // CPU/pad side: issues requests, supplies serial data, reads results.
    modport master (
        output start, clear_pressed, controller_1_data_in_B, controller_2_data_in_B,
        input  controller_clk, controller_latch,
        input  controller_1_buttons_out, controller_2_buttons_out,
        input  controller_1_pressed_out, controller_2_pressed_out,
        input  busy, valid
    );

    // Poller side.
    modport slave (
        input  start, clear_pressed, controller_1_data_in_B, controller_2_data_in_B,
        output controller_clk, controller_latch,
        output controller_1_buttons_out, controller_2_buttons_out,
        output controller_1_pressed_out, controller_2_pressed_out,
        output busy, valid
    );

endinterface

// File: rtl/controller_poller_m_channel.sv
// One controller port: serial shift register, committed button byte and sticky pressed mask.
module controller_channel_m
    import controller_poller_m_pkg::*;
(
    input  logic                    clk_12_5875,
    input  logic                    rst,
    input  logic                    i_data_B,
    input  logic                    i_sample,
    input  logic                    i_commit,
    input  logic                    i_clear,
    output logic [BUTTON_COUNT-1:0] o_buttons,
    output logic [BUTTON_COUNT-1:0] o_pressed
);

    logic [BUTTON_COUNT-1:0] r_shift;
    logic [BUTTON_COUNT-1:0] r_buttons;
    logic [BUTTON_COUNT-1:0] r_pressed;
    logic [BUTTON_COUNT-1:0] w_new;
    logic [BUTTON_COUNT-1:0] w_pressed_base;

    // Incoming data is active low; the first bit received ends up in bit 0.
    assign w_new          = ~r_shift;
    // A clear in the commit cycle wipes the old mask before new edges are merged in.
    assign w_pressed_base = i_clear ? '0 : r_pressed;

    // Shift in on sample strobes; buttons and pressed mask only change on commit or clear.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_shift   <= '0;
            r_buttons <= '0;
            r_pressed <= '0;
        end else begin
            if (i_sample) begin
                r_shift <= {i_data_B, r_shift[BUTTON_COUNT-1:1]};
            end
            if (i_commit) begin
                r_buttons <= w_new;
                r_pressed <= w_pressed_base | (w_new & ~r_buttons);
            end else if (i_clear) begin
                r_pressed <= '0;
            end
        end
    end

    assign o_buttons = r_buttons;
    assign o_pressed = r_pressed;

endmodule

// File: rtl/controller_poller_m.sv
// Polls two NES-style serial controllers: latch pulse, eight clocked bit slots, atomic commit.
module controller_poller_m
    import controller_poller_m_pkg::*;
#(
    parameter int HALF_PERIOD = 6
) (
    input  logic                  clk_12_5875,
    input  logic                  rst,
    controller_poller_m_if.slave  bus,
    output poll_state_t           o_dbg_state
);

    localparam int CW = $clog2(2 * HALF_PERIOD + 1);
    localparam int BW = $clog2(BUTTON_COUNT);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(2 * HALF_PERIOD - 1);
    localparam logic [CW-1:0] SHIFT_LOAD = CW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(BUTTON_COUNT - 1);

    poll_state_t    r_state;
    poll_state_t    w_next_state;
    logic [CW-1:0]  r_presc;
    logic [CW-1:0]  w_presc_next;
    logic [BW-1:0]  r_bit;
    logic [BW-1:0]  w_bit_next;
    logic           w_sample;
    logic           w_commit;
    logic           r_latch;
    logic           r_clk;
    logic           r_busy;
    logic           r_valid;
    logic [BUTTON_COUNT-1:0] w_btn1;
    logic [BUTTON_COUNT-1:0] w_btn2;
    logic [BUTTON_COUNT-1:0] w_prs1;
    logic [BUTTON_COUNT-1:0] w_prs2;

    // Next state, bit index, prescaler reload and the sample/commit strobes.
    always_comb begin
        w_next_state = r_state;
        w_bit_next   = r_bit;
        w_sample     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                w_bit_next = '0;
                if (bus.start) begin
                    w_next_state = LATCH;
                end
            end
            LATCH: begin
                if (r_presc == '0) begin
                    w_next_state = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // Data is taken on the last low cycle, well after the pad has settled.
                if (r_presc == '0) begin
                    w_sample     = 1'b1;
                    w_next_state = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (r_presc == '0) begin
                    if (r_bit == LAST_BIT) begin
                        w_next_state = COMMIT;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_next_state = SHIFT_LO;
                    end
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        w_presc_next = r_presc;
        if (w_next_state != r_state) begin
            case (w_next_state)
                LATCH:              w_presc_next = LATCH_LOAD;
                SHIFT_LO, SHIFT_HI: w_presc_next = SHIFT_LOAD;
                default:            w_presc_next = '0;
            endcase
        end else if (r_presc != '0) begin
            w_presc_next = r_presc - 1'b1;
        end
    end

    // State, counters and pad/status outputs; outputs are decoded from the next
    // state so each registered output lines up with the state it describes.
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_bit   <= '0;
            r_latch <= 1'b0;
            r_clk   <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_presc <= w_presc_next;
            r_bit   <= w_bit_next;
            r_latch <= (w_next_state == LATCH);
            r_clk   <= (w_next_state != SHIFT_LO);
            r_busy  <= (w_next_state == LATCH) || (w_next_state == SHIFT_LO) ||
                       (w_next_state == SHIFT_HI);
            r_valid <= (w_next_state == COMMIT);
        end
    end

    controller_channel_m u_port1 (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .i_data_B    (bus.controller_1_data_in_B),
        .i_sample    (w_sample),
        .i_commit    (w_commit),
        .i_clear     (bus.clear_pressed),
        .o_buttons   (w_btn1),
        .o_pressed   (w_prs1)
    );

    controller_channel_m u_port2 (
        .clk_12_5875 (clk_12_5875),
        .rst         (rst),
        .i_data_B    (bus.controller_2_data_in_B),
        .i_sample    (w_sample),
        .i_commit    (w_commit),
        .i_clear     (bus.clear_pressed),
        .o_buttons   (w_btn2),
        .o_pressed   (w_prs2)
    );

    assign bus.controller_clk           = r_clk;
    assign bus.controller_latch         = r_latch;
    assign bus.busy                     = r_busy;
    assign bus.valid                    = r_valid;
    assign bus.controller_1_buttons_out = w_btn1;
    assign bus.controller_2_buttons_out = w_btn2;
    assign bus.controller_1_pressed_out = w_prs1;
    assign bus.controller_2_pressed_out = w_prs2;
    assign o_dbg_state                  = r_state;

endmodule
